// File: rtl/ps2_device_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_device_tx_if
//  Description : Byte handshake between a producer and the PS/2 device-side
//                frame generator (valid/ready in, done/busy status out).
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_device_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_done;
   logic       busy;

   // Producer side: offers bytes, observes status.
   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  tx_done,
      input  busy
   );

   // Frame generator side: consumes bytes, reports status.
   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output tx_done,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/ps2_device_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_device_tx
//  Description : PS/2 device-to-host frame generator (keyboard emulation).
//                Serialises accepted bytes into 11-bit frames (start, 8 data
//                LSB first, odd parity, stop) on push-pull ps2_clk/ps2_data.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_device_tx #(
   parameter int unsigned CLK_DIV    = 8,
   parameter int unsigned GAP_CYCLES = 16
) (
   input  wire logic      clk,
   input  wire logic      resetn,
   ps2_device_tx_if.slave tx_if,
   output logic           ps2_clk,
   output logic           ps2_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   localparam logic [15:0] C_DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] C_GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [3:0]  C_LAST_BIT = 4'd10;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  bit_idx_q, bit_idx_d;
   logic [10:0] shift_q, shift_d;
   logic        ps2_clk_q, ps2_clk_d;
   logic        ps2_data_q, ps2_data_d;
   logic        tx_done_q, tx_done_d;

   logic        accept;

   // A byte is taken only while idle; everything else ignores tx_valid.
   assign accept = (state_q == S_IDLE) && tx_if.tx_valid;

   // Next-state and next-output computation for the frame sequencer.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 16'd1;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      ps2_clk_d  = ps2_clk_q;
      ps2_data_d = ps2_data_q;
      tx_done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d      = 16'd0;
            ps2_clk_d  = 1'b1;
            ps2_data_d = 1'b1;
            if (accept) begin
               // Frame: stop, odd parity, data, start (start goes out first).
               shift_d    = {1'b1, ~^tx_if.tx_data, tx_if.tx_data, 1'b0};
               bit_idx_d  = 4'd0;
               ps2_data_d = 1'b0;
               state_d    = S_HIGH;
            end
         end
         S_HIGH: begin
            if (cnt_q == C_DIV_LAST) begin
               cnt_d     = 16'd0;
               ps2_clk_d = 1'b0;
               state_d   = S_LOW;
            end
         end
         S_LOW: begin
            if (cnt_q == C_DIV_LAST) begin
               cnt_d     = 16'd0;
               ps2_clk_d = 1'b1;
               if (bit_idx_q == C_LAST_BIT) begin
                  ps2_data_d = 1'b1;
                  tx_done_d  = 1'b1;
                  state_d    = S_GAP;
               end else begin
                  // Data only moves together with the rising clock edge.
                  bit_idx_d  = bit_idx_q + 4'd1;
                  ps2_data_d = shift_q[bit_idx_q + 4'd1];
                  state_d    = S_HIGH;
               end
            end
         end
         S_GAP: begin
            ps2_clk_d  = 1'b1;
            ps2_data_d = 1'b1;
            if (cnt_q == C_GAP_LAST) begin
               cnt_d   = 16'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            cnt_d   = 16'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Register the sequencer state and all line outputs; reset aborts a frame.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         bit_idx_q  <= 4'd0;
         shift_q    <= 11'h7FF;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         ps2_clk_q  <= ps2_clk_d;
         ps2_data_q <= ps2_data_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign ps2_clk        = ps2_clk_q;
   assign ps2_data       = ps2_data_q;
   assign tx_if.tx_ready = (state_q == S_IDLE);
   assign tx_if.busy     = (state_q != S_IDLE);
   assign tx_if.tx_done  = tx_done_q;

endmodule
`default_nettype wire

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
PS/2 device-side frame generator that emulates a keyboard. It serialises bytes (scan codes) into 11-bit PS/2 device-to-host frames on ps2_clk/ps2_data. It drives the team's PS/2 keyboard receiver in simulation and NVBoard loopback tests. It also serves as the transmit half of a future PS/2 device model. Input side is a valid/ready byte handshake. Output lines are driven push-pull and idle high.

Parameters:
CLK_DIV, 8, system clk cycles per ps2_clk half-period; legal range 4..65535 (receiver's 3-flop edge detect needs >=4).
GAP_CYCLES, 16, system clk cycles of idle-high between frames; legal range 1..65535.

Ports:
clk  input  1  system clock
resetn  input  1  synchronous, active-low reset
tx_data  input  8  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a byte this cycle
tx_done  output  1  one-cycle pulse, frame finished
busy  output  1  frame or gap in progress (= ~tx_ready)
ps2_clk  output  1  PS/2 clock line
ps2_data  output  1  PS/2 data line

Behaviour:
- Reset (resetn==0 at posedge clk): state IDLE, ps2_clk=1, ps2_data=1, tx_ready=1, busy=0, tx_done=0, counters cleared. Reset mid-frame aborts immediately: lines high the next cycle, no tx_done, the partial byte is dropped.
- Handshake: accept at the posedge where tx_valid && tx_ready. tx_valid while tx_ready=0 is ignored; no buffering. tx_data is sampled only at acceptance.
- Frame latched at acceptance, shift[10:0] = {1 stop=1, parity, data[7:0], start=0}. Bits are sent shift[0] first, so data goes LSB first.
- Parity is odd: parity = ~^tx_data, so data+parity has an odd number of ones.
- States:
  - IDLE: lines high, ready=1; on accept go to HIGH, bit_idx=0.
  - HIGH: ps2_clk=1, ps2_data=shift[bit_idx] for CLK_DIV cycles, then go to LOW.
  - LOW: ps2_clk=0, ps2_data held unchanged for CLK_DIV cycles. Then if bit_idx==10 go to GAP, else bit_idx+1 and go to HIGH.
  - GAP: ps2_clk=1, ps2_data=1 for GAP_CYCLES cycles; tx_done=1 on the first GAP cycle only; then go to IDLE.
- Data changes only in the cycle ps2_clk rises (or enters HIGH from IDLE). It is never changed while ps2_clk=0.
- Timing: accept at cycle T. HIGH runs T+1..T+CLK_DIV. First falling edge at T+CLK_DIV+1. Exactly 11 low phases per frame. GAP starts at T+22*CLK_DIV+1. tx_ready returns at T+22*CLK_DIV+GAP_CYCLES+1. Back-to-back accept is possible in that same cycle.
- tx_ready=1 only in IDLE, so it is combinational from state. Outputs are registered (no glitches on ps2_clk/ps2_data).
- Widths: bit_idx 4 bits, saturating check at 10. Half-period counter is 16 bits, counts 0..CLK_DIV-1 and wraps to 0 on every state change. Gap counter is the same counter, reused.
- tx_done and tx_valid in the same cycle: no interaction. Acceptance happens only in IDLE, after the gap.

Test Plan:
- CLK_DIV=4, GAP=16, send 0x1C -> ps2_data over the 11 low phases = 0,0,0,1,1,1,0,0,0,0,1 (parity 0); exactly 11 ps2_clk falling edges; tx_done at T+89; receiver outputs data=0x1C.
- Send 0xF0 then 0x1C with tx_valid held high continuously -> parity bits 1 and 0; tx_ready low for 88+16 cycles between accepts; receiver logs f0 then 1c, nothing else.
- Send 0x00 and 0xFF -> parity 1 for both; receiver accepts both; tx_valid pulses while busy are ignored (no third frame).
- Assert resetn=0 for 1 cycle after the 5th ps2_clk falling edge of 0xAA -> next cycle ps2_clk=ps2_data=1, tx_ready=1, no tx_done; a new 0x55 then sends cleanly and the receiver reads 0x55.
- Run with CLK_DIV=50 -> each ps2_clk low and high phase lasts exactly 50 cycles; ps2_data never toggles while ps2_clk=0 (assertion over 1000 random bytes; receiver matches every byte).
